// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - D-stage stall decision, E/M hazard shadow registers and mult/div sequencing
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic [4:0] A3_D,
    input  logic       RegWr_D,
    input  logic [1:0] Tnew_D,
    input  logic       md_D,
    input  logic [1:0] md_op_D,
    output logic       stall,
    output logic [4:0] A3_E,
    output logic [4:0] A3_M,
    output logic       RegWr_E,
    output logic       RegWr_M,
    output logic [1:0] Tnew_E,
    output logic [1:0] Tnew_M,
    output logic       md_start,
    output logic       md_busy
);

    logic [CNT_W-1:0] busy_cnt;
    logic [1:0]       md_op_E;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;

    // A source index of 0 or a Tuse of 3 means the operand is not a real dependency.
    assign stall_rs = (A1_D != 5'd0) && (Tuse_rs_D != 2'd3) &&
                      ((RegWr_E && (A3_E == A1_D) && (Tnew_E > Tuse_rs_D)) ||
                       (RegWr_M && (A3_M == A1_D) && (Tnew_M > Tuse_rs_D)));

    assign stall_rt = (A2_D != 5'd0) && (Tuse_rt_D != 2'd3) &&
                      ((RegWr_E && (A3_E == A2_D) && (Tnew_E > Tuse_rt_D)) ||
                       (RegWr_M && (A3_M == A2_D) && (Tnew_M > Tuse_rt_D)));

    // An op sitting in E has not yet loaded the counter, so it blocks md-class instrs too.
    assign stall_md = md_D && (md_busy || (md_op_E != 2'b00));
    assign stall    = stall_rs | stall_rt | stall_md;
    assign md_busy  = (busy_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A3_E     <= 5'd0;
            RegWr_E  <= 1'b0;
            Tnew_E   <= 2'd0;
            md_op_E  <= 2'b00;
            A3_M     <= 5'd0;
            RegWr_M  <= 1'b0;
            Tnew_M   <= 2'd0;
            md_start <= 1'b0;
            busy_cnt <= '0;
        end else begin
            if (stall) begin
                A3_E    <= 5'd0;
                RegWr_E <= 1'b0;
                Tnew_E  <= 2'd0;
                md_op_E <= 2'b00;
            end else begin
                A3_E    <= A3_D;
                RegWr_E <= RegWr_D;
                Tnew_E  <= Tnew_D;
                md_op_E <= md_op_D;
            end

            A3_M    <= A3_E;
            RegWr_M <= RegWr_E;
            Tnew_M  <= (Tnew_E == 2'd0) ? 2'd0 : (Tnew_E - 2'd1);

            // Pulse lines up with the op's E cycle, when md_op_E selects the busy length.
            md_start <= !stall && (md_op_D != 2'b00);

            if (md_start) begin
                busy_cnt <= (md_op_E == 2'b01) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] A1_D;
    logic [4:0] A2_D;
    logic [1:0] Tuse_rs_D;
    logic [1:0] Tuse_rt_D;
    logic [4:0] A3_D;
    logic       RegWr_D;
    logic [1:0] Tnew_D;
    logic       md_D;
    logic [1:0] md_op_D;
    logic       stall;
    logic [4:0] A3_E;
    logic [4:0] A3_M;
    logic       RegWr_E;
    logic       RegWr_M;
    logic [1:0] Tnew_E;
    logic [1:0] Tnew_M;
    logic       md_start;
    logic       md_busy;

    typedef struct packed {
        logic       stall;
        logic [4:0] a3e;
        logic       rwe;
        logic [1:0] tne;
        logic [4:0] a3m;
        logic       rwm;
        logic [1:0] tnm;
        logic       start;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A1_D      (A1_D),
        .A2_D      (A2_D),
        .Tuse_rs_D (Tuse_rs_D),
        .Tuse_rt_D (Tuse_rt_D),
        .A3_D      (A3_D),
        .RegWr_D   (RegWr_D),
        .Tnew_D    (Tnew_D),
        .md_D      (md_D),
        .md_op_D   (md_op_D),
        .stall     (stall),
        .A3_E      (A3_E),
        .A3_M      (A3_M),
        .RegWr_E   (RegWr_E),
        .RegWr_M   (RegWr_M),
        .Tnew_E    (Tnew_E),
        .Tnew_M    (Tnew_M),
        .md_start  (md_start),
        .md_busy   (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ex(input logic s, input logic [4:0] a3e, input logic rwe,
                                input logic [1:0] tne, input logic [4:0] a3m, input logic rwm,
                                input logic [1:0] tnm, input logic st, input logic bz);
        exp_t e;
        e.stall = s;   e.a3e = a3e; e.rwe = rwe; e.tne = tne;
        e.a3m   = a3m; e.rwm = rwm; e.tnm = tnm; e.start = st; e.busy = bz;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [4:0] a1, input logic [1:0] tr, input logic [4:0] a2,
                         input logic [1:0] tt, input logic [4:0] a3, input logic rw,
                         input logic [1:0] tn, input logic md, input logic [1:0] op);
        A1_D = a1; Tuse_rs_D = tr; A2_D = a2; Tuse_rt_D = tt;
        A3_D = a3; RegWr_D = rw; Tnew_D = tn; md_D = md; md_op_D = op;
    endtask

    task automatic nop();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 2'b00);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".stall"},    {7'd0, stall},    {7'd0, e.stall});
        chk({tag, ".A3_E"},     {3'd0, A3_E},     {3'd0, e.a3e});
        chk({tag, ".RegWr_E"},  {7'd0, RegWr_E},  {7'd0, e.rwe});
        chk({tag, ".Tnew_E"},   {6'd0, Tnew_E},   {6'd0, e.tne});
        chk({tag, ".A3_M"},     {3'd0, A3_M},     {3'd0, e.a3m});
        chk({tag, ".RegWr_M"},  {7'd0, RegWr_M},  {7'd0, e.rwm});
        chk({tag, ".Tnew_M"},   {6'd0, Tnew_M},   {6'd0, e.tnm});
        chk({tag, ".md_start"}, {7'd0, md_start}, {7'd0, e.start});
        chk({tag, ".md_busy"},  {7'd0, md_busy},  {7'd0, e.busy});
    endtask

    // Inputs already driven at the falling edge; check the cycle, then advance one clock.
    task automatic step(input string tag, input exp_t e);
        sb.push_back(e);
        #1;
        compare(tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        #1;
        sb.push_back(ex(0, 0,0,0, 0,0,0, 0,0));
        compare("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // lw $1 then addu $2,$1,$3
        drive(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 1'b1, 2'd2, 1'b0, 2'b00);
        step("lw1", ex(0, 0,0,0, 0,0,0, 0,0));
        drive(5'd1, 2'd1, 5'd3, 2'd1, 5'd2, 1'b1, 2'd1, 1'b0, 2'b00);
        step("addu_stall", ex(1, 1,1,2, 0,0,0, 0,0));
        step("addu_go",    ex(0, 0,0,0, 1,1,1, 0,0));
        nop();
        step("addu_e",     ex(0, 2,1,1, 0,0,0, 0,0));
        step("addu_m",     ex(0, 0,0,0, 2,1,0, 0,0));
        step("drain1",     ex(0, 0,0,0, 0,0,0, 0,0));

        // lw $1 then beq $1,$0
        drive(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 1'b1, 2'd2, 1'b0, 2'b00);
        step("lw2", ex(0, 0,0,0, 0,0,0, 0,0));
        drive(5'd1, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'b00);
        step("beq_stall_e", ex(1, 1,1,2, 0,0,0, 0,0));
        step("beq_stall_m", ex(1, 0,0,0, 1,1,1, 0,0));
        step("beq_go",      ex(0, 0,0,0, 0,0,0, 0,0));
        nop();
        step("drain2",      ex(0, 0,0,0, 0,0,0, 0,0));

        // writes to $0, Tnew 0 producer and saturation of Tnew_M
        drive(5'd3, 2'd1, 5'd4, 2'd1, 5'd0, 1'b1, 2'd1, 1'b0, 2'b00);
        step("addu_r0", ex(0, 0,0,0, 0,0,0, 0,0));
        drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 2'b00);
        step("use_r0",  ex(0, 0,1,1, 0,0,0, 0,0));
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 1'b1, 2'd0, 1'b0, 2'b00);
        step("lui5",    ex(0, 0,0,0, 0,1,0, 0,0));
        drive(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 2'b00);
        step("beq5",    ex(0, 5,1,0, 0,0,0, 0,0));
        nop();
        step("sat_m",   ex(0, 0,0,0, 5,1,0, 0,0));
        step("drain3",  ex(0, 0,0,0, 0,0,0, 0,0));

        // mult then mflo
        drive(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, 2'b01);
        step("mult", ex(0, 0,0,0, 0,0,0, 0,0));
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 1'b1, 2'd1, 1'b1, 2'b00);
        step("mflo_start", ex(1, 0,0,0, 0,0,0, 1,0));
        for (int i = 0; i < 5; i++) begin
            step("mflo_busy", ex(1, 0,0,0, 0,0,0, 0,1));
        end
        step("mflo_go", ex(0, 0,0,0, 0,0,0, 0,0));
        nop();
        step("mflo_e",  ex(0, 6,1,1, 0,0,0, 0,0));
        step("mflo_m",  ex(0, 0,0,0, 6,1,0, 0,0));
        step("drain4",  ex(0, 0,0,0, 0,0,0, 0,0));

        // div, unrelated addu stream, second div while busy
        drive(5'd7, 2'd1, 5'd8, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, 2'b10);
        step("div1", ex(0, 0,0,0, 0,0,0, 0,0));
        drive(5'd7, 2'd1, 5'd8, 2'd1, 5'd9, 1'b1, 2'd1, 1'b0, 2'b00);
        step("addu_s0", ex(0, 0,0,0, 0,0,0, 1,0));
        step("addu_s1", ex(0, 9,1,1, 0,0,0, 0,1));
        step("addu_s2", ex(0, 9,1,1, 9,1,0, 0,1));
        drive(5'd10, 2'd1, 5'd11, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, 2'b10);
        step("div2_stall0", ex(1, 9,1,1, 9,1,0, 0,1));
        step("div2_stall1", ex(1, 0,0,0, 9,1,0, 0,1));
        for (int i = 0; i < 6; i++) begin
            step("div2_busy", ex(1, 0,0,0, 0,0,0, 0,1));
        end
        step("div2_go", ex(0, 0,0,0, 0,0,0, 0,0));
        nop();
        step("div2_start", ex(0, 0,0,0, 0,0,0, 1,0));
        drive(5'd7, 2'd1, 5'd8, 2'd1, 5'd9, 1'b1, 2'd1, 1'b0, 2'b00);
        step("div2_cnt10", ex(0, 0,0,0, 0,0,0, 0,1));
        step("div2_cnt9",  ex(0, 9,1,1, 0,0,0, 0,1));
        for (int i = 0; i < 4; i++) begin
            step("div2_cnt", ex(0, 9,1,1, 9,1,0, 0,1));
        end

        // count is 4 now: asynchronous reset mid-operation
        sb.push_back(ex(0, 9,1,1, 9,1,0, 0,1));
        #1;
        compare("pre_reset");
        rst_n = 1'b0;
        #1;
        sb.push_back(ex(0, 0,0,0, 0,0,0, 0,0));
        compare("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 1'b1, 2'd2, 1'b0, 2'b00);
        step("post_lw", ex(0, 0,0,0, 0,0,0, 0,0));
        nop();
        step("post_e",  ex(0, 1,1,2, 0,0,0, 0,0));
        step("post_m",  ex(0, 0,0,0, 1,1,1, 0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall controller for the 5-stage MIPS pipeline. Compares D-stage Tuse against E/M-stage Tnew and decides when to stall.
- Owns the E/M hazard shadow registers (A3, RegWr, Tnew). These feed the forwarding unit.
- Sequences the multi-cycle mult/div unit: issues the start pulse, counts busy cycles and blocks md-class instructions while the unit is busy.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult start
- DIV_CYCLES, 10, busy cycles after div start
- CNT_W, 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- A1_D  input  5  rs index of D instr
- A2_D  input  5  rt index of D instr
- Tuse_rs_D  input  2  cycles until rs needed (0..2); 3 = rs unused
- Tuse_rt_D  input  2  same for rt
- A3_D  input  5  destination of D instr
- RegWr_D  input  1  D instr writes GPR
- Tnew_D  input  2  Tnew of D instr on entering E (0..2)
- md_D  input  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- md_op_D  input  2  00 none, 01 mult/multu, 10 div/divu
- stall  output  1  freeze PC and F/D; insert bubble into D/E
- A3_E, A3_M  output  5  E/M destination registers
- RegWr_E, RegWr_M  output  1  E/M write enables
- Tnew_E, Tnew_M  output  2  E/M remaining Tnew
- md_start  output  1  one-cycle start pulse to the mult/div unit
- md_busy  output  1  mult/div unit busy

Behaviour:
- Reset (async, rst_n=0):
  - All registered outputs are 0: A3_E/M, RegWr_E/M, Tnew_E/M, md_start, busy counter, md_op_E.
  - stall=0 (combinational on zeroed state).
- Hazard stall (combinational):
  - stall_rs = A1_D!=0 && Tuse_rs_D!=3 && ((RegWr_E && A3_E==A1_D && Tnew_E>Tuse_rs_D) || (RegWr_M && A3_M==A1_D && Tnew_M>Tuse_rs_D)).
  - stall_rt is the same with A2_D and Tuse_rt_D.
- md stall: stall_md = md_D && (md_busy || md_op_E!=00).
- Combination: stall = stall_rs | stall_rt | stall_md.
- Pipeline registers (every cycle):
  - If stall: E is loaded with a bubble (A3_E=0, RegWr_E=0, Tnew_E=0, md_op_E=00).
  - Else: E loads A3_D, RegWr_D, Tnew_D and md_op_D.
  - M always loads from E: A3_M=A3_E, RegWr_M=RegWr_E, Tnew_M = Tnew_E==0 ? 0 : Tnew_E-1 (saturates, never wraps).
- Mult/div sequencing:
  - md_start is registered: md_start=1 in the cycle after md_op_E!=00 was loaded, i.e. coincident with the op's E stage. Pulse width is exactly 1.
  - On md_start, the counter loads MULT_CYCLES (op 01) or DIV_CYCLES (op 10).
  - Otherwise the counter decrements while nonzero and holds at 0.
  - md_busy = counter!=0.
  - After a mult, busy lasts exactly MULT_CYCLES cycles; after a div, DIV_CYCLES cycles.
- Simultaneous events:
  - An md start while the counter is nonzero cannot occur, because stall_md prevents it.
  - A hazard stall and an md stall together produce a single stall, with no double bubble.
  - A stalled D instr re-evaluates every cycle; stall drops the first cycle the condition clears.
- Register 0: never triggers a stall; A3=0 writes are ignored by the comparisons.
- Reset mid-operation: counter clears immediately, md_busy drops, pending md_start is lost, E/M become bubbles.

Test Plan:
- lw $1 (Tnew_D=2) followed by addu $2,$1,$3 (Tuse_rs=1) → stall=1 for 1 cycle. The bubble has RegWr_E=0. Next cycle Tnew_M=1 and stall=0 (Tnew_M 1 ≤ Tuse 1).
- lw $1 then beq $1 (Tuse_rs=0) → stall for 2 cycles: E match with Tnew 2, then M match with Tnew 1. Released when Tnew reaches 0.
- addu $0 then use $0 at Tuse 0 → stall stays 0. Tnew_M saturates at 0 from Tnew_E=0.
- mult then mflo immediately → md_start pulses 1 cycle later. md_busy is high for 5 cycles and mflo is stalled for 6 cycles (E occupancy plus busy). Then stall=0.
- div then an unrelated addu stream → addu never stalls. md_busy high for 10 cycles. A second div while busy stalls until the counter reaches 0.
- Assert rst_n=0 at busy count 4 → md_busy=0 and all E/M outputs 0 immediately (asynchronous). After release the first instruction enters E cleanly.
